stream_demux_rr: RTL and testbench

Registered one-to-N stream demultiplexer with valid/ready handshakes on both sides. It is the counterpart of the 2:1 select mux: one upstream stream is steered into one of `N_OUT` downstream streams. Each output has its own one-entry holding register, so a stalled consumer blocks only traffic addressed to it. Destination is chosen round-robin by default, or by an explicit select when the configuration macro is enabled.

---
 rtl/stream_demux_pkg.sv | 16 +
 rtl/stream_demux_rr_if.sv | 49 ++++
 rtl/stream_slot.sv | 35 +++
 rtl/stream_demux_rr.sv | 101 ++++++++++
 tb/tb_stream_demux_rr.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the round-robin / selectable stream demultiplexer.
package stream_demux_pkg;

    localparam int DEF_N_OUT = 4;
    localparam int DEF_WIDTH = 8;

    // Index width for n ports, never narrower than one bit
    function automatic int sel_w(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/stream_demux_rr_if.sv
// Upstream/downstream handshake bundle for stream_demux_rr.
// The up_sel field exists only when STREAM_DEMUX_SEL_EN is defined.
interface stream_demux_rr_if
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int WIDTH = DEF_WIDTH
) ();

    localparam int SEL_W = sel_w(N_OUT);

    logic                   up_valid;
    logic                   up_ready;
    logic [WIDTH-1:0]       up_data;
`ifdef STREAM_DEMUX_SEL_EN
    logic [SEL_W-1:0]       up_sel;
`endif
    logic [N_OUT-1:0]       down_valid;
    logic [N_OUT-1:0]       down_ready;
    logic [N_OUT*WIDTH-1:0] down_data;
    logic                   drop;

    modport master (
        output up_valid,
        output up_data,
`ifdef STREAM_DEMUX_SEL_EN
        output up_sel,
`endif
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_data,
        input  drop
    );

    modport slave (
        input  up_valid,
        input  up_data,
`ifdef STREAM_DEMUX_SEL_EN
        input  up_sel,
`endif
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_data,
        output drop
    );

endinterface

// File: rtl/stream_slot.sv
// One-entry valid/ready holding register; a load wins over a drain in the same cycle.
module stream_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot state: load refills (even while draining), drain alone empties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux_rr.sv
// One-to-N registered stream demultiplexer, round-robin destination by default.
// Defining STREAM_DEMUX_SEL_EN routes by up_sel instead and drops out-of-range beats.
module stream_demux_rr
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    stream_demux_rr_if.slave  bus
);

    localparam int SEL_W = sel_w(N_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0]       w_dst;
    logic                   w_in_range;
    logic                   w_busy;
    logic                   w_accept;
    logic [N_OUT-1:0]       w_load;
    logic [N_OUT-1:0]       w_vld;
    logic [N_OUT*WIDTH-1:0] w_dat;

`ifdef STREAM_DEMUX_SEL_EN
    logic r_drop;

    assign w_dst      = bus.up_sel;
    assign w_in_range = ({1'b0, bus.up_sel} <= {1'b0, LAST_IDX});

    // Out-of-range beats are swallowed; flag them on the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept & ~w_in_range;
        end
    end

    assign bus.drop = r_drop;
`else
    logic [SEL_W-1:0] r_ptr;

    assign w_dst      = r_ptr;
    assign w_in_range = 1'b1;

    // Pointer moves only on accepted beats and wraps explicitly for any N_OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (r_ptr == LAST_IDX) ? SEL_W'(0) : r_ptr + SEL_W'(1);
        end
    end

    assign bus.drop = 1'b0;
`endif

    // Destination is busy when it holds a beat its consumer will not take
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_dst == SEL_W'(i)) begin
                w_busy = w_vld[i] & ~bus.down_ready[i];
            end else begin
                w_busy = w_busy;
            end
        end
    end

    assign bus.up_ready = ~w_in_range | ~w_busy;
    assign w_accept     = bus.up_valid & bus.up_ready;

    // One-hot load strobe towards the selected slot
    always_comb begin
        w_load = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (w_dst == SEL_W'(i)) begin
                w_load[i] = w_accept & w_in_range;
            end else begin
                w_load[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        stream_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_data  (bus.up_data),
            .i_ready (bus.down_ready[g]),
            .o_valid (w_vld[g]),
            .o_data  (w_dat[g*WIDTH +: WIDTH])
        );
    end

    assign bus.down_valid = w_vld;
    assign bus.down_data  = w_dat;

endmodule

// File: tb/tb_stream_demux_rr.sv
// Self-checking bench for stream_demux_rr: scoreboard on a 4-port instance plus
// directed checks on a 3-port instance (select tests only with STREAM_DEMUX_SEL_EN).
module tb_stream_demux_rr;
    import stream_demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    stream_demux_rr_if #(.N_OUT(4), .WIDTH(8)) b4 ();
    stream_demux_rr_if #(.N_OUT(3), .WIDTH(8)) b3 ();

    stream_demux_rr #(.N_OUT(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    stream_demux_rr #(.N_OUT(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Scoreboard: per-port queue of beats expected on the 4-port instance
    logic [7:0] sb_q [4][$];
    int         m_ptr      = 0;
    bit         mon_en     = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    bit         exp_v;
    bit         exp_rdy;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                exp_v = (sb_q[i].size() != 0);
                n_chk++;
                if (b4.down_valid[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_valid port %0d: got %b expected %b", i, b4.down_valid[i], exp_v);
                end
                if (exp_v) begin
                    n_chk++;
                    if (b4.down_data[i*8 +: 8] !== sb_q[i][0]) begin
                        n_fail++;
                        $display("FAIL sb_data port %0d: got %02h expected %02h", i, b4.down_data[i*8 +: 8], sb_q[i][0]);
                    end
                end
            end
            n_chk++;
            if (b4.drop !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_drop: got %b expected 0", b4.drop);
            end
            if (b4.up_valid === 1'b1) begin
                exp_rdy = (sb_q[m_ptr].size() == 0) || (b4.down_ready[m_ptr] === 1'b1);
                n_chk++;
                if (b4.up_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL sb_up_ready: got %b expected %b (dst %0d)", b4.up_ready, exp_rdy, m_ptr);
                end
                if (prev_stall) begin
                    n_chk++;
                    if (b4.up_data !== prev_data) begin
                        n_fail++;
                        $display("FAIL up_data_stable: got %02h expected %02h", b4.up_data, prev_data);
                    end
                end
            end
            if (rst) begin
                for (int i = 0; i < 4; i++) sb_q[i].delete();
                m_ptr = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (b4.down_valid[i] && b4.down_ready[i] && sb_q[i].size() != 0)
                        void'(sb_q[i].pop_front());
                end
                if (b4.up_valid && b4.up_ready) begin
                    sb_q[m_ptr].push_back(b4.up_data);
                    m_ptr = (m_ptr == 3) ? 0 : m_ptr + 1;
                end
            end
            prev_stall = b4.up_valid && !b4.up_ready && !rst;
            prev_data  = b4.up_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat to the 4-port instance and wait (bounded) until accepted
    task automatic push_beat(input logic [7:0] d);
        int n;
        n = 0;
        b4.up_valid = 1'b1;
        b4.up_data  = d;
`ifdef STREAM_DEMUX_SEL_EN
        b4.up_sel   = 2'(m_ptr);
`endif
        @(negedge clk);
        while (b4.up_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout data %02h: up_ready stayed %b, required 1", d, b4.up_ready);
        end
        tick();
        b4.up_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (b4.down_valid !== 4'b0000 || b4.down_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset4: valid %b data %08h, required 0000 / 00000000", b4.down_valid, b4.down_data);
        end
        n_chk++;
        if (b3.down_valid !== 3'b000 || b3.down_data !== 24'h0 || b3.drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset3: valid %b data %06h drop %b, required 000 / 000000 / 0", b3.down_valid, b3.down_data, b3.drop);
        end
        n_chk++;
        if (b4.up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_up_ready: got %b required 1", b4.up_ready);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        b4.down_ready = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                b4.up_valid = 1'b1;
                b4.up_data  = 8'h10 + 8'(k);
`ifdef STREAM_DEMUX_SEL_EN
                b4.up_sel   = 2'(k % 4);
`endif
            end else begin
                b4.up_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8) begin
                n_chk++;
                if (b4.up_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_up_ready beat %0d: got %b required 1", k, b4.up_ready);
                end
            end
            if (k >= 1) begin
                n_chk++;
                if (b4.down_valid !== (4'b0001 << ((k - 1) % 4)) ||
                    b4.down_data[((k - 1) % 4)*8 +: 8] !== 8'h10 + 8'(k - 1)) begin
                    n_fail++;
                    $display("FAIL rr_route beat %0d: valid %b data %08h, required port %0d data %02h",
                             k - 1, b4.down_valid, b4.down_data, (k - 1) % 4, 8'h10 + 8'(k - 1));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        b4.down_ready = 4'b1101;
        push_beat(8'hA0);
        push_beat(8'hA1);
        push_beat(8'hA2);
        push_beat(8'hA3);
        push_beat(8'hA4);
        b4.up_valid = 1'b1;
        b4.up_data  = 8'hA5;
`ifdef STREAM_DEMUX_SEL_EN
        b4.up_sel   = 2'd1;
`endif
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_chk++;
            if (b4.up_ready !== 1'b0 || b4.down_valid[1] !== 1'b1 || b4.down_data[15:8] !== 8'hA1) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: up_ready %b valid1 %b data1 %02h, required 0 / 1 / a1",
                         c, b4.up_ready, b4.down_valid[1], b4.down_data[15:8]);
            end
            tick();
        end
        b4.down_ready = 4'b1111;
        @(negedge clk);
        n_chk++;
        if (b4.up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: up_ready %b required 1", b4.up_ready);
        end
        tick();
        b4.up_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b4.down_valid[1] !== 1'b1 || b4.down_data[15:8] !== 8'hA5) begin
            n_fail++;
            $display("FAIL stall_refill: valid1 %b data1 %02h, required 1 / a5", b4.down_valid[1], b4.down_data[15:8]);
        end
        tick();
    endtask

    task automatic test_drain_load();
        b4.down_ready = 4'b1011;
        push_beat(8'h55);
        push_beat(8'h01);
        push_beat(8'h02);
        push_beat(8'h03);
        b4.up_valid   = 1'b1;
        b4.up_data    = 8'h66;
`ifdef STREAM_DEMUX_SEL_EN
        b4.up_sel     = 2'd2;
`endif
        b4.down_ready = 4'b1111;
        @(negedge clk);
        n_chk++;
        if (b4.up_ready !== 1'b1 || b4.down_valid[2] !== 1'b1 || b4.down_data[23:16] !== 8'h55) begin
            n_fail++;
            $display("FAIL dl_before: up_ready %b valid2 %b data2 %02h, required 1 / 1 / 55",
                     b4.up_ready, b4.down_valid[2], b4.down_data[23:16]);
        end
        tick();
        b4.up_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b4.down_valid[2] !== 1'b1 || b4.down_data[23:16] !== 8'h66) begin
            n_fail++;
            $display("FAIL dl_after: valid2 %b data2 %02h, required 1 / 66", b4.down_valid[2], b4.down_data[23:16]);
        end
        tick();
    endtask

    task automatic test_wrap3();
        b3.down_ready = 3'b111;
        for (int k = 0; k <= 7; k++) begin
            if (k < 7) begin
                b3.up_valid = 1'b1;
                b3.up_data  = 8'h30 + 8'(k);
`ifdef STREAM_DEMUX_SEL_EN
                b3.up_sel   = 2'(k % 3);
`endif
            end else begin
                b3.up_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 7) begin
                n_chk++;
                if (b3.up_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap3_up_ready beat %0d: got %b required 1", k, b3.up_ready);
                end
            end
            if (k >= 1) begin
                n_chk++;
                if (b3.down_valid !== (3'b001 << ((k - 1) % 3)) ||
                    b3.down_data[((k - 1) % 3)*8 +: 8] !== 8'h30 + 8'(k - 1)) begin
                    n_fail++;
                    $display("FAIL wrap3_route beat %0d: valid %b data %06h, required port %0d data %02h",
                             k - 1, b3.down_valid, b3.down_data, (k - 1) % 3, 8'h30 + 8'(k - 1));
                end
            end
            tick();
        end
    endtask

`ifdef STREAM_DEMUX_SEL_EN
    task automatic test_sel();
        b3.down_ready = 3'b111;
        b3.up_valid   = 1'b1;
        b3.up_data    = 8'h3C;
        b3.up_sel     = 2'd2;
        @(negedge clk);
        n_chk++;
        if (b3.up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_up_ready: got %b required 1", b3.up_ready);
        end
        tick();
        b3.up_data = 8'h99;
        b3.up_sel  = 2'd3;
        @(negedge clk);
        n_chk++;
        if (b3.down_valid !== 3'b100 || b3.down_data[23:16] !== 8'h3C || b3.drop !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_route: valid %b data2 %02h drop %b, required 100 / 3c / 0",
                     b3.down_valid, b3.down_data[23:16], b3.drop);
        end
        n_chk++;
        if (b3.up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_oor_ready: got %b required 1", b3.up_ready);
        end
        tick();
        b3.up_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b3.down_valid !== 3'b000 || b3.drop !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_drop: valid %b drop %b, required 000 / 1", b3.down_valid, b3.drop);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (b3.drop !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_drop_pulse: drop %b required 0", b3.drop);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        b4.down_ready = 4'b0110;
        push_beat(8'hB3);
        push_beat(8'hB0);
        @(negedge clk);
        n_chk++;
        if (b4.down_valid !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid %b required 1001", b4.down_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b4.down_valid !== 4'b0000 || b4.down_data !== 32'h0 || b4.up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_clear: valid %b data %08h up_ready %b, required 0000 / 00000000 / 1",
                     b4.down_valid, b4.down_data, b4.up_ready);
        end
        tick();
        b4.down_ready = 4'b1111;
        b4.up_valid   = 1'b1;
        b4.up_data    = 8'hC0;
`ifdef STREAM_DEMUX_SEL_EN
        b4.up_sel     = 2'd0;
`endif
        tick();
        b4.up_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b4.down_valid !== 4'b0001 || b4.down_data[7:0] !== 8'hC0) begin
            n_fail++;
            $display("FAIL rstmid_next: valid %b data0 %02h, required 0001 / c0", b4.down_valid, b4.down_data[7:0]);
        end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        b4.up_valid   = 1'b0;
        b4.up_data    = 8'h00;
        b4.down_ready = 4'b1111;
        b3.up_valid   = 1'b0;
        b3.up_data    = 8'h00;
        b3.down_ready = 3'b111;
`ifdef STREAM_DEMUX_SEL_EN
        b4.up_sel     = 2'd0;
        b3.up_sel     = 2'd0;
`endif
        test_reset();
        test_round_robin();
        test_stall();
        test_drain_load();
        test_wrap3();
`ifdef STREAM_DEMUX_SEL_EN
        test_sel();
`endif
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
